// File: rtl/rs_station.sv
// ---------------------------------------------------------------------------
// rs_station -- reservation station for ALU/branch ops.
//
// Buffers renamed ops from the issuer. Pending source tags are resolved by
// snooping the RS (ALU) and LSB (load) result buses. At most one
// operand-ready entry is sent to the ALU per cycle, lowest index first, and
// all ALU outputs are registered.
//
// Optional feature (macro RS_BYPASS_EN):
//   An inserted op whose operands are ready after bus capture goes straight
//   to the ALU outputs on the same edge, without allocating an entry. This
//   happens only when no table entry is ready.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   rdy                  global enable (low = freeze)
//   reset_from_rob_bus   mispredict flush
//   *_from_issuer        insert request (dest != 0) with op, tags and values
//   dest/value_from_rss_bus, dest/value_from_lsb_bus  result buses (dest 0 = idle)
//   is_full              high when free entries <= 1
//   *_to_alu             registered dispatch; dest_to_alu != 0 means valid
// ---------------------------------------------------------------------------
module rs_station #(
  parameter int RS_SIZE  = 8,
  parameter int RS_IDX_W = 3,
  parameter int ROB_ID_W = 4,
  parameter int OP_W     = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                reset_from_rob_bus,
  input  logic [ROB_ID_W-1:0] dest_from_issuer,
  input  logic [OP_W-1:0]     op_from_issuer,
  input  logic [ROB_ID_W-1:0] qj_from_issuer,
  input  logic [ROB_ID_W-1:0] qk_from_issuer,
  input  logic [31:0]         vj_from_issuer,
  input  logic [31:0]         vk_from_issuer,
  input  logic [31:0]         imm_from_issuer,
  input  logic [31:0]         pc_from_issuer,
  input  logic [ROB_ID_W-1:0] dest_from_rss_bus,
  input  logic [31:0]         value_from_rss_bus,
  input  logic [ROB_ID_W-1:0] dest_from_lsb_bus,
  input  logic [31:0]         value_from_lsb_bus,
  output logic                is_full,
  output logic [ROB_ID_W-1:0] dest_to_alu,
  output logic [OP_W-1:0]     op_to_alu,
  output logic [31:0]         vj_to_alu,
  output logic [31:0]         vk_to_alu,
  output logic [31:0]         imm_to_alu,
  output logic [31:0]         pc_to_alu
);

  localparam int CNT_W = RS_IDX_W + 1;

  typedef struct packed {
    logic [ROB_ID_W-1:0] q;
    logic [31:0]         v;
  } operand_t;

  // Resolve one source operand against both result buses; rss has precedence.
  function automatic operand_t capture(
    input logic [ROB_ID_W-1:0] q,       input logic [31:0] v,
    input logic [ROB_ID_W-1:0] rss_tag, input logic [31:0] rss_val,
    input logic [ROB_ID_W-1:0] lsb_tag, input logic [31:0] lsb_val);
    operand_t r;
    r.q = q;
    r.v = v;
    if (q != '0 && q == rss_tag) begin
      r.q = '0;
      r.v = rss_val;
    end else if (q != '0 && q == lsb_tag) begin
      r.q = '0;
      r.v = lsb_val;
    end
    return r;
  endfunction

  logic [RS_SIZE-1:0]  busy;
  logic [ROB_ID_W-1:0] ent_dest [RS_SIZE];
  logic [OP_W-1:0]     ent_op   [RS_SIZE];
  logic [ROB_ID_W-1:0] ent_qj   [RS_SIZE];
  logic [ROB_ID_W-1:0] ent_qk   [RS_SIZE];
  logic [31:0]         ent_vj   [RS_SIZE];
  logic [31:0]         ent_vk   [RS_SIZE];
  logic [31:0]         ent_imm  [RS_SIZE];
  logic [31:0]         ent_pc   [RS_SIZE];
  logic [CNT_W-1:0]    count;

  logic [RS_SIZE-1:0]  ready;
  logic                any_ready;
  logic                any_free;
  logic [RS_IDX_W-1:0] disp_idx;
  logic [RS_IDX_W-1:0] free_idx;
  logic                insert_req;
  logic                do_bypass;
  logic                do_insert;
  operand_t            ins_j;
  operand_t            ins_k;

  // Registered count only, so the flag is stable for the whole cycle. The
  // one-entry margin covers an insert already in flight from the issuer.
  assign is_full = (count >= CNT_W'(RS_SIZE - 1));

  // NOTE: every comb output gets a default before any conditional update, so
  // no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    disp_idx = '0;
    free_idx = '0;
    ready    = '0;
    // Scan downwards so the lowest matching index is the one kept.
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      ready[i] = busy[i] && ent_qj[i] == '0 && ent_qk[i] == '0;
      if (ready[i]) disp_idx = RS_IDX_W'(i);
      if (!busy[i]) free_idx = RS_IDX_W'(i);
    end
    any_ready  = |ready;
    any_free   = ~&busy;
    insert_req = dest_from_issuer != '0;
    ins_j = capture(qj_from_issuer, vj_from_issuer, dest_from_rss_bus,
                    value_from_rss_bus, dest_from_lsb_bus, value_from_lsb_bus);
    ins_k = capture(qk_from_issuer, vk_from_issuer, dest_from_rss_bus,
                    value_from_rss_bus, dest_from_lsb_bus, value_from_lsb_bus);
`ifdef RS_BYPASS_EN
    do_bypass = insert_req && ins_j.q == '0 && ins_k.q == '0 && !any_ready;
`else
    do_bypass = 1'b0;
`endif
    // Free slots come from registered busy: a slot vacated by this edge's
    // dispatch is not offered to the insert on the same edge.
    do_insert = insert_req && any_free && !do_bypass;
  end

  // NOTE: all state is updated with non-blocking assignments so every entry
  // sees the pre-edge values, independent of statement order.
  // NOTE: only busy, count and the ALU outputs are reset; entry payloads are
  // don't-care while busy is low and are left unreset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= '0;
      count       <= '0;
      dest_to_alu <= '0;
      op_to_alu   <= '0;
      vj_to_alu   <= '0;
      vk_to_alu   <= '0;
      imm_to_alu  <= '0;
      pc_to_alu   <= '0;
    end else if (!rdy) begin
      dest_to_alu <= '0;
    end else if (reset_from_rob_bus) begin
      busy        <= '0;
      count       <= '0;
      dest_to_alu <= '0;
      op_to_alu   <= '0;
      vj_to_alu   <= '0;
      vk_to_alu   <= '0;
      imm_to_alu  <= '0;
      pc_to_alu   <= '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i]) begin
          operand_t sj, sk;
          sj = capture(ent_qj[i], ent_vj[i], dest_from_rss_bus,
                       value_from_rss_bus, dest_from_lsb_bus, value_from_lsb_bus);
          sk = capture(ent_qk[i], ent_vk[i], dest_from_rss_bus,
                       value_from_rss_bus, dest_from_lsb_bus, value_from_lsb_bus);
          ent_qj[i] <= sj.q;
          ent_vj[i] <= sj.v;
          ent_qk[i] <= sk.q;
          ent_vk[i] <= sk.v;
        end
      end

      if (any_ready) begin
        dest_to_alu    <= ent_dest[disp_idx];
        op_to_alu      <= ent_op[disp_idx];
        vj_to_alu      <= ent_vj[disp_idx];
        vk_to_alu      <= ent_vk[disp_idx];
        imm_to_alu     <= ent_imm[disp_idx];
        pc_to_alu      <= ent_pc[disp_idx];
        busy[disp_idx] <= 1'b0;
      end else if (do_bypass) begin
        dest_to_alu <= dest_from_issuer;
        op_to_alu   <= op_from_issuer;
        vj_to_alu   <= ins_j.v;
        vk_to_alu   <= ins_k.v;
        imm_to_alu  <= imm_from_issuer;
        pc_to_alu   <= pc_from_issuer;
      end else begin
        dest_to_alu <= '0;
      end

      // The chosen slot is not busy, so the snoop loop above never touches it.
      if (do_insert) begin
        busy[free_idx]     <= 1'b1;
        ent_dest[free_idx] <= dest_from_issuer;
        ent_op[free_idx]   <= op_from_issuer;
        ent_qj[free_idx]   <= ins_j.q;
        ent_vj[free_idx]   <= ins_j.v;
        ent_qk[free_idx]   <= ins_k.q;
        ent_vk[free_idx]   <= ins_k.v;
        ent_imm[free_idx]  <= imm_from_issuer;
        ent_pc[free_idx]   <= pc_from_issuer;
      end

      count <= count + CNT_W'(do_insert) - CNT_W'(any_ready);
    end
  end

`ifndef SYNTHESIS
  // The issuer must respect is_full; an insert with no free slot is dropped.
  insert_overflow: assert property (@(posedge clk) disable iff (rst)
    !(rdy && !reset_from_rob_bus && insert_req && !any_free && !do_bypass))
    else $error("rs_station: insert with no free entry");
`endif

endmodule

// File: tb/tb_rs_station.sv
module tb_rs_station;
  localparam int RS_SIZE  = 8;
  localparam int RS_IDX_W = 3;
  localparam int ROB_ID_W = 4;
  localparam int OP_W     = 6;

  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic [3:0]  dest_in, qj_in, qk_in, rss_dest, lsb_dest;
  logic [5:0]  op_in;
  logic [31:0] vj_in, vk_in, imm_in, pc_in, rss_val, lsb_val;
  logic        is_full;
  logic [3:0]  dest_to_alu;
  logic [5:0]  op_to_alu;
  logic [31:0] vj_to_alu, vk_to_alu, imm_to_alu, pc_to_alu;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rs_station #(.RS_SIZE(RS_SIZE), .RS_IDX_W(RS_IDX_W), .ROB_ID_W(ROB_ID_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .reset_from_rob_bus(flush),
    .dest_from_issuer(dest_in), .op_from_issuer(op_in),
    .qj_from_issuer(qj_in), .qk_from_issuer(qk_in),
    .vj_from_issuer(vj_in), .vk_from_issuer(vk_in),
    .imm_from_issuer(imm_in), .pc_from_issuer(pc_in),
    .dest_from_rss_bus(rss_dest), .value_from_rss_bus(rss_val),
    .dest_from_lsb_bus(lsb_dest), .value_from_lsb_bus(lsb_val),
    .is_full(is_full), .dest_to_alu(dest_to_alu), .op_to_alu(op_to_alu),
    .vj_to_alu(vj_to_alu), .vk_to_alu(vk_to_alu),
    .imm_to_alu(imm_to_alu), .pc_to_alu(pc_to_alu));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a list of slots holding ops, plus the expected ALU outputs.
  typedef struct {
    bit          busy;
    logic [3:0]  dest, qj, qk;
    logic [5:0]  op;
    logic [31:0] vj, vk, imm, pc;
  } ent_t;

  ent_t        m [RS_SIZE];
  logic [3:0]  e_dest;
  logic [5:0]  e_op;
  logic [31:0] e_vj, e_vk, e_imm, e_pc;

  function automatic int occupancy();
    int n = 0;
    foreach (m[i]) if (m[i].busy) n++;
    return n;
  endfunction

  // A pending tag seen on a bus this cycle becomes a value (rss first).
  function automatic void resolve(inout logic [3:0] q, inout logic [31:0] v);
    if (q != 0 && q == rss_dest) begin q = 0; v = rss_val; end
    else if (q != 0 && q == lsb_dest) begin q = 0; v = lsb_val; end
  endfunction

  task automatic clear_model();
    foreach (m[i]) m[i].busy = 0;
    e_dest = 0; e_op = 0; e_vj = 0; e_vk = 0; e_imm = 0; e_pc = 0;
  endtask

  task automatic model_step();
    ent_t nxt [RS_SIZE];
    int d = -1, f = -1;
    bit byp = 0;
    logic [3:0] cj = qj_in, ck = qk_in;
    logic [31:0] wj = vj_in, wk = vk_in;
    if (rst) begin clear_model(); return; end
    if (!rdy) begin e_dest = 0; return; end
    if (flush) begin clear_model(); return; end
    foreach (m[i]) begin
      if (d < 0 && m[i].busy && m[i].qj == 0 && m[i].qk == 0) d = i;
      if (f < 0 && !m[i].busy) f = i;
    end
    resolve(cj, wj);
    resolve(ck, wk);
`ifdef RS_BYPASS_EN
    byp = (dest_in != 0) && cj == 0 && ck == 0 && d < 0;
`endif
    nxt = m;
    foreach (nxt[i]) if (nxt[i].busy) begin
      resolve(nxt[i].qj, nxt[i].vj);
      resolve(nxt[i].qk, nxt[i].vk);
    end
    if (d >= 0) begin
      e_dest = m[d].dest; e_op = m[d].op; e_vj = m[d].vj; e_vk = m[d].vk;
      e_imm = m[d].imm; e_pc = m[d].pc;
      nxt[d].busy = 0;
    end else if (byp) begin
      e_dest = dest_in; e_op = op_in; e_vj = wj; e_vk = wk; e_imm = imm_in; e_pc = pc_in;
    end else begin
      e_dest = 0;
    end
    if (dest_in != 0 && !byp && f >= 0) begin
      nxt[f].busy = 1; nxt[f].dest = dest_in; nxt[f].op = op_in;
      nxt[f].qj = cj; nxt[f].vj = wj; nxt[f].qk = ck; nxt[f].vk = wk;
      nxt[f].imm = imm_in; nxt[f].pc = pc_in;
    end
    m = nxt;
  endtask

  // One clock: advance the model on the inputs the DUT samples, then compare.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("m_dest", dest_to_alu, e_dest);
    check("m_full", is_full, occupancy() >= RS_SIZE - 1);
    if (e_dest != 0) begin
      check("m_op", op_to_alu, e_op);
      check("m_vj", vj_to_alu, e_vj);
      check("m_vk", vk_to_alu, e_vk);
      check("m_imm", imm_to_alu, e_imm);
      check("m_pc", pc_to_alu, e_pc);
    end
  endtask

  task automatic idle();
    dest_in = 0; op_in = 0; qj_in = 0; qk_in = 0; vj_in = 0; vk_in = 0;
    imm_in = 0; pc_in = 0; rss_dest = 0; rss_val = 0; lsb_dest = 0; lsb_val = 0;
  endtask

  task automatic ins(input logic [3:0] d, input logic [3:0] qj, input logic [3:0] qk,
                     input logic [31:0] vj, input logic [31:0] vk);
    dest_in = d; qj_in = qj; qk_in = qk; vj_in = vj; vk_in = vk;
    op_in = 6'(d + 1); imm_in = 32'h100 + 32'(d); pc_in = 32'h8000 + 32'(d) * 4;
  endtask

  initial begin
    clear_model();
    idle();
    rst = 1; rdy = 1; flush = 0;
    tick(); tick();
    check("rst_dest", dest_to_alu, 0);
    check("rst_full", is_full, 0);
    rst = 0;

    // 1: ready insert reaches the ALU after 2 edges (1 with bypass)
    ins(3, 0, 0, 5, 7);
    tick(); idle();
`ifdef RS_BYPASS_EN
    check("t1_dest", dest_to_alu, 3);
    check("t1_vj", vj_to_alu, 5);
    check("t1_vk", vk_to_alu, 7);
    tick();
`else
    check("t1_early", dest_to_alu, 0);
    tick();
    check("t1_dest", dest_to_alu, 3);
    check("t1_vj", vj_to_alu, 5);
    check("t1_vk", vk_to_alu, 7);
`endif
    tick();

    // 2: wakeup from the rss bus
    ins(4, 2, 0, 0, 1);
    tick(); idle();
    rss_dest = 2; rss_val = 32'h10;
    tick(); idle();
    tick();
    check("t2_dest", dest_to_alu, 4);
    check("t2_vj", vj_to_alu, 32'h10);

    // 3: tag captured from the lsb bus at insert time
    ins(5, 6, 0, 0, 2);
    lsb_dest = 6; lsb_val = 9;
    tick(); idle();
`ifndef RS_BYPASS_EN
    tick();
`endif
    check("t3_dest", dest_to_alu, 5);
    check("t3_vj", vj_to_alu, 9);
    tick();

    // 4: fill to 7 unresolved entries, then release one
    for (int i = 0; i < 7; i++) begin
      ins(4'(i + 1), 4'(i + 9), 0, 0, 0);
      tick();
      if (i == 5) check("t4_full6", is_full, 0);
    end
    idle();
    check("t4_full7", is_full, 1);
    rss_dest = 9; rss_val = 32'h99;
    tick(); idle();
    tick();
    check("t4_dest", dest_to_alu, 1);
    check("t4_vj", vj_to_alu, 32'h99);
    check("t4_full", is_full, 0);
    flush = 1; tick(); flush = 0;

    // 5: ready entries at 0, 2, 5 leave in index order
    for (int i = 0; i < 6; i++) begin
      ins(4'(i + 1), (i == 0 || i == 2 || i == 5) ? 4'd10 : 4'd11, 0, 32'(i), 0);
      tick();
    end
    idle();
    rss_dest = 10; rss_val = 32'h55;
    tick(); idle();
    tick(); check("t5_first", dest_to_alu, 1);
    tick(); check("t5_second", dest_to_alu, 3);
    tick(); check("t5_third", dest_to_alu, 6);
    tick(); check("t5_none", dest_to_alu, 0);

    // 6: flush with 4 busy entries and an insert pending
    ins(8, 11, 0, 0, 0);
    tick();
    ins(9, 0, 0, 1, 1);
    flush = 1;
    tick(); flush = 0; idle();
    check("t6_dest", dest_to_alu, 0);
    check("t6_full", is_full, 0);
    rss_dest = 11; rss_val = 1;
    tick(); idle();
    tick();
    check("t6_empty", dest_to_alu, 0);

    // rdy low freezes the table: no insert, no snoop, no dispatch
    ins(7, 12, 0, 0, 3);
    tick(); idle();
    rss_dest = 12; rss_val = 32'hab;
    tick();
    rdy = 0;
    ins(8, 0, 0, 4, 4);
    rss_dest = 13; rss_val = 32'hcd;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("frz_dest", dest_to_alu, 0);
    end
    rdy = 1; idle();
    tick();
    check("frz_resume", dest_to_alu, 7);
    check("frz_vj", vj_to_alu, 32'hab);
    tick();
    check("frz_after", dest_to_alu, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      idle();
      rst   = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 63) == 0);
      rdy   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 1) == 1 && occupancy() < RS_SIZE) begin
        dest_in = 4'($urandom_range(1, 15));
        op_in   = 6'($urandom);
        qj_in   = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15));
        qk_in   = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15));
        vj_in = $urandom; vk_in = $urandom; imm_in = $urandom; pc_in = $urandom;
      end
      if ($urandom_range(0, 2) != 0) begin
        rss_dest = 4'($urandom_range(1, 15)); rss_val = $urandom;
      end
      if ($urandom_range(0, 2) == 0) begin
        lsb_dest = 4'($urandom_range(1, 15)); lsb_val = $urandom;
      end
      tick();
    end
    rst = 0; flush = 0; rdy = 1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
